// File: rtl/spi_ram_burst_pkg.sv
// Shared command encoding for the SPI RAM back-end.
// Each received word carries a 2-bit command prefix above the payload field.
package spi_ram_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Command/read-data bus between the SPI front-end (master) and the RAM back-end (slave).
// The slave holds off new commands while its read word is still waiting to be taken.
interface spi_ram_burst_if
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [DATA_W+CMD_W-1:0] din;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [DATA_W-1:0]       dout;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    err;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, err
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, err
  );

endinterface

// File: rtl/spi_ram_burst_mem.sv
// Storage array for the SPI RAM: one write and one registered read per cycle, no reset.
// The read register only updates when enabled, so it keeps the last word read.
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// RAM back-end for the SPI slave: command decode, independent burst pointers,
// ready/valid flow control on both sides and a sticky out-of-range flag.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_burst_if.slave   bus
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              tx_valid_q;
  logic              dout_zero;
  logic              err_q;
  logic [DATA_W-1:0] mem_rdata;

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              mem_we;
  logic              mem_re;

  // Pointers wrap to zero at the end of the array, and also when parked out of range.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    if (int'(ptr) >= MEM_DEPTH - 1) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign cmd         = cmd_t'(bus.din[DATA_W+CMD_W-1:DATA_W]);
  assign payload     = bus.din[DATA_W-1:0];
  assign bus.rx_ready = !tx_valid_q || bus.tx_ready;
  assign accept      = bus.rx_valid && bus.rx_ready;
  assign wr_in_range = int'(wr_ptr) < MEM_DEPTH;
  assign rd_in_range = int'(rd_ptr) < MEM_DEPTH;
  assign mem_we      = accept && (cmd == CMD_WR_DATA) && wr_in_range;
  assign mem_re      = accept && (cmd == CMD_RD_DATA) && rd_in_range;

  // dout_zero masks the un-reset memory read register after reset and on out-of-range reads.
  assign bus.dout     = dout_zero ? '0 : mem_rdata;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;

  spi_ram_mem #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (payload),
    .re    (mem_re),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_valid_q <= 1'b0;
      dout_zero  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        unique case (cmd)
          CMD_WR_ADDR: wr_ptr <= payload[ADDR_W-1:0];
          CMD_WR_DATA: begin
            if (!wr_in_range) begin
              err_q <= 1'b1;
            end
            if (AUTO_INC != 0) begin
              wr_ptr <= next_ptr(wr_ptr);
            end
          end
          CMD_RD_ADDR: rd_ptr <= payload[ADDR_W-1:0];
          CMD_RD_DATA: begin
            dout_zero <= !rd_in_range;
            if (!rd_in_range) begin
              err_q <= 1'b1;
            end
            if (AUTO_INC != 0) begin
              rd_ptr <= next_ptr(rd_ptr);
            end
          end
        endcase
      end
      // A new read replaces the pending word in the same cycle it is taken.
      if (accept && (cmd == CMD_RD_DATA)) begin
        tx_valid_q <= 1'b1;
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Drives three differently-parameterised RAM back-ends with one shared stimulus stream
// and compares each against a word-level model of the command set.
module tb_spi_ram_burst;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;

  always #5 clk = ~clk;

  spi_ram_burst_if #(.DATA_W(8)) bus_a ();
  spi_ram_burst_if #(.DATA_W(8)) bus_b ();
  spi_ram_burst_if #(.DATA_W(8)) bus_c ();

  assign bus_a.din = din;  assign bus_a.rx_valid = rx_valid;  assign bus_a.tx_ready = tx_ready;
  assign bus_b.din = din;  assign bus_b.rx_valid = rx_valid;  assign bus_b.tx_ready = tx_ready;
  assign bus_c.din = din;  assign bus_c.rx_valid = rx_valid;  assign bus_c.tx_ready = tx_ready;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  logic       rdy [N];
  logic       tv  [N];
  logic       er  [N];
  logic [7:0] dq  [N];

  assign rdy[0] = bus_a.rx_ready;  assign tv[0] = bus_a.tx_valid;  assign er[0] = bus_a.err;  assign dq[0] = bus_a.dout;
  assign rdy[1] = bus_b.rx_ready;  assign tv[1] = bus_b.tx_valid;  assign er[1] = bus_b.err;  assign dq[1] = bus_b.dout;
  assign rdy[2] = bus_c.rx_ready;  assign tv[2] = bus_c.tx_valid;  assign er[2] = bus_c.err;  assign dq[2] = bus_c.dout;

  // Reference state: memory with a written-yet mask, pointers as plain integers.
  logic [7:0] m_mem   [N][256];
  bit         m_known [N][256];
  int         m_wp    [N];
  int         m_rp    [N];
  logic [7:0] m_dout  [N];
  bit         m_dk    [N];
  bit         m_err   [N];
  bit         m_tv;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int depth_of(input int k);
    return (k == 1) ? 200 : 256;
  endfunction

  function automatic bit inc_of(input int k);
    return (k == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic int bump(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_wp[k]   = 0;
      m_rp[k]   = 0;
      m_dout[k] = 8'h00;
      m_dk[k]   = 1'b1;
      m_err[k]  = 1'b0;
    end
    m_tv = 1'b0;
  endtask

  task automatic model_cmd(input int k, input logic [1:0] c, input logic [7:0] p);
    case (c)
      2'b00: m_wp[k] = int'(p);
      2'b01: begin
        if (m_wp[k] < depth_of(k)) begin
          m_mem[k][m_wp[k]]   = p;
          m_known[k][m_wp[k]] = 1'b1;
        end else begin
          m_err[k] = 1'b1;
        end
        if (inc_of(k)) m_wp[k] = bump(m_wp[k], depth_of(k));
      end
      2'b10: m_rp[k] = int'(p);
      default: begin
        if (m_rp[k] < depth_of(k)) begin
          m_dout[k] = m_mem[k][m_rp[k]];
          m_dk[k]   = m_known[k][m_rp[k]];
        end else begin
          m_dout[k] = 8'h00;
          m_dk[k]   = 1'b1;
          m_err[k]  = 1'b1;
        end
        if (inc_of(k)) m_rp[k] = bump(m_rp[k], depth_of(k));
      end
    endcase
  endtask

  task automatic check_output();
    for (int k = 0; k < N; k++) begin
      check("tx_valid", k, 32'(tv[k]), 32'(m_tv));
      check("err", k, 32'(er[k]), 32'(m_err[k]));
      if (m_dk[k]) check("dout", k, 32'(dq[k]), 32'(m_dout[k]));
    end
  endtask

  // One cycle starting at a falling edge: present inputs, check ready, clock, check outputs.
  task automatic apply_stimulus(input bit v, input logic [1:0] c, input logic [7:0] p, input bit tr);
    bit exp_rdy;
    bit acc;
    din      = {c, p};
    rx_valid = v;
    tx_ready = tr;
    #1;
    exp_rdy = !m_tv || tr;
    for (int k = 0; k < N; k++) check("rx_ready", k, 32'(rdy[k]), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc && c == 2'b11) m_tv = 1'b1;
    else if (tr) m_tv = 1'b0;
    if (acc) begin
      for (int k = 0; k < N; k++) model_cmd(k, c, p);
    end
    #1;
    check_output();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) check("reset_rx_ready", k, 32'(rdy[k]), 32'd1);
    check_output();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back.
    apply_stimulus(1, 2'b00, 8'h10, 1);
    apply_stimulus(1, 2'b01, 8'hA5, 1);
    apply_stimulus(1, 2'b10, 8'h10, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    // Burst across the top of the address space.
    apply_stimulus(1, 2'b00, 8'hFE, 1);
    apply_stimulus(1, 2'b01, 8'h11, 1);
    apply_stimulus(1, 2'b01, 8'h22, 1);
    apply_stimulus(1, 2'b01, 8'h33, 1);
    apply_stimulus(1, 2'b10, 8'hFE, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    // Back-pressure: a pending read word holds off a write.
    apply_stimulus(1, 2'b10, 8'h10, 1);
    apply_stimulus(1, 2'b11, 8'h00, 0);
    apply_stimulus(1, 2'b01, 8'h99, 0);
    apply_stimulus(1, 2'b01, 8'h99, 0);
    apply_stimulus(1, 2'b01, 8'h99, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    // Out-of-range for the 200-deep instance.
    apply_stimulus(1, 2'b00, 8'hC8, 1);
    apply_stimulus(1, 2'b01, 8'h5A, 1);
    apply_stimulus(1, 2'b10, 8'hC8, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    // Repeated reads from a static pointer.
    apply_stimulus(1, 2'b00, 8'h20, 1);
    apply_stimulus(1, 2'b01, 8'h7E, 1);
    apply_stimulus(1, 2'b10, 8'h20, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end
    apply_stimulus(0, 2'b00, 8'h00, 1);

    // Reset while a read word is stalled.
    apply_stimulus(1, 2'b10, 8'h10, 1);
    apply_stimulus(1, 2'b11, 8'h00, 0);
    apply_stimulus(0, 2'b00, 8'h00, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) check("rst_rx_ready", k, 32'(rdy[k]), 32'd1);
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1, 2'b10, 8'h10, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(1, 2'b11, 8'h00, 1);
    apply_stimulus(0, 2'b00, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
